// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding imem requester feeding a first-word-fall-through queue.
// Optional stall/flush performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     f_valid,
  input  logic                     f_ready,
  output logic [31:0]              f_instruction,
  output logic [XLEN-1:0]          f_pc,
  output logic [XLEN-1:0]          f_pc_plus4,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_flush
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // DRAIN doubles as the discard flag: the outstanding response must be dropped.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q [DEPTH];

  logic issue;
  logic push;
  logic pop;

  assign issue = (state_q == ST_IDLE) && (count_q < CW'(DEPTH)) && !redirect && reset;
  assign push  = (state_q == ST_WAIT) && imem_ack && !redirect;
  assign pop   = f_valid && f_ready && !redirect;

  assign imem_req      = issue;
  assign imem_addr     = pc_q;
  assign q_count       = count_q;
  assign f_valid       = (count_q != '0);
  assign f_instruction = f_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign f_pc          = f_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign f_pc_plus4    = f_valid ? (pc_mem_q[rd_ptr_q] + XLEN'(4)) : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tag_d    = tag_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    // An ack that coincides with a redirect retires the request, so no drain is needed.
    case (state_q)
      ST_IDLE:  if (issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_ack)      state_d = ST_IDLE;
        else if (redirect) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (imem_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (issue) begin
      pc_d  = pc_q + XLEN'(4);
      tag_d = pc_q;
    end
    if (redirect) pc_d = redirect_pc;

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      tag_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; head outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= tag_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (f_valid && !f_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall = stall_cnt_q;
  assign perf_flush = flush_cnt_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order memory responder.
module tb_fetch_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             redirect = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             f_valid;
  logic             f_ready = 1'b0;
  logic [31:0]      f_instruction;
  logic [XLEN-1:0]  f_pc;
  logic [XLEN-1:0]  f_pc_plus4;
  logic [2:0]       q_count;
  logic [31:0]      perf_stall;
  logic [31:0]      perf_flush;

  logic             model_ack = 1'b0;
  logic [31:0]      model_rdata = '0;
  logic             manual_ack = 1'b0;
  logic [31:0]      manual_rdata = '0;
  int               mem_lat = 1;
  logic [31:0]      issued[$];

  int tests = 0;
  int failed = 0;

  assign imem_ack   = model_ack | manual_ack;
  assign imem_rdata = manual_ack ? manual_rdata : model_rdata;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .f_valid(f_valid), .f_ready(f_ready),
    .f_instruction(f_instruction), .f_pc(f_pc), .f_pc_plus4(f_pc_plus4),
    .q_count(q_count), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: latches a request seen mid-cycle and acks mem_lat edges later.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    pend = 1'b0; pend_addr = '0; cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        pend = 1'b0; model_ack = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          model_ack = 1'b1; model_rdata = mem_word(pend_addr); pend = 1'b0;
        end else model_ack = 1'b0;
      end else model_ack = 1'b0;
      #1;
      if (reset && imem_req) begin
        pend = 1'b1; pend_addr = imem_addr; cnt = mem_lat; issued.push_back(imem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    tick();
    reset = 1'b0; redirect = 1'b0; f_ready = rdy; mem_lat = lat; manual_ack = 1'b0;
    tick();
    tick();
    issued.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    f_ready = 1'b0; redirect = 1'b0; mem_lat = 1;
    repeat (3) tick();
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL reset_req: got %0h expected 0", imem_req); end
    tests++; if (f_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %0h expected 0", f_valid); end
    tests++; if (q_count !== 3'd0) begin failed++; $display("[TB] FAIL reset_count: got %0d expected 0", q_count); end
    tests++; if (imem_addr !== 32'h0) begin failed++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
    tests++; if ({f_instruction, f_pc, f_pc_plus4} !== 96'h0) begin failed++; $display("[TB] FAIL reset_head: got %h/%h/%h expected 0", f_instruction, f_pc, f_pc_plus4); end
    tests++; if ({perf_stall, perf_flush} !== 64'h0) begin failed++; $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall, perf_flush); end
    tick();
    reset = 1'b1; manual_ack = 1'b1; manual_rdata = 32'hDEAD_BEEF;
    #3;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("[TB] FAIL release_req: got %0h@%h expected 1@0", imem_req, imem_addr); end
    tick();
    manual_ack = 1'b0;
    #3;
    tests++; if (q_count !== 3'd0 || imem_req !== 1'b0) begin failed++; $display("[TB] FAIL early_ack_ignored: got count %0d req %0h expected 0 0", q_count, imem_req); end
    tick();
    #3;
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'h0 || f_instruction !== mem_word(32'h0)) begin failed++; $display("[TB] FAIL first_fetch: got %0h pc %h ins %h expected 1 0 %h", f_valid, f_pc, f_instruction, mem_word(32'h0)); end
  endtask

  task automatic test_sequential();
    logic [31:0] s_pc[$];
    logic [31:0] s_p4[$];
    logic [31:0] s_in[$];
    do_reset(1, 1'b1);
    #3;
    for (int i = 0; i < 16; i++) begin
      if (f_valid) begin s_pc.push_back(f_pc); s_p4.push_back(f_pc_plus4); s_in.push_back(f_instruction); end
      tick();
      #3;
    end
    tests++;
    if (issued.size() < 3 || s_pc.size() < 3) begin
      failed++; $display("[TB] FAIL seq_len: got %0d issued %0d popped expected >=3", issued.size(), s_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (issued[i] !== 32'(4 * i)) begin failed++; $display("[TB] FAIL seq_addr%0d: got %h expected %h", i, issued[i], 32'(4 * i)); end
        tests++; if (s_pc[i] !== 32'(4 * i) || s_p4[i] !== 32'(4 * i + 4)) begin failed++; $display("[TB] FAIL seq_pc%0d: got %h/%h expected %h/%h", i, s_pc[i], s_p4[i], 32'(4 * i), 32'(4 * i + 4)); end
        tests++; if (s_in[i] !== mem_word(32'(4 * i))) begin failed++; $display("[TB] FAIL seq_ins%0d: got %h expected %h", i, s_in[i], mem_word(32'(4 * i))); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0);
    repeat (12) tick();
    #3;
    tests++; if (q_count !== 3'd4 || issued.size() != 4) begin failed++; $display("[TB] FAIL full_count: got count %0d issued %0d expected 4 4", q_count, issued.size()); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #3;
      tests++; if (imem_req !== 1'b0 || f_pc !== 32'h0) begin failed++; $display("[TB] FAIL full_hold%0d: got req %0h pc %h expected 0 0", i, imem_req, f_pc); end
    end
    tick();
    f_ready = 1'b1;
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL full_pop_req: got %0h expected 0", imem_req); end
    tick();
    f_ready = 1'b0;
    #3;
    tests++; if (q_count !== 3'd3 || f_pc !== 32'h4) begin failed++; $display("[TB] FAIL after_pop: got count %0d pc %h expected 3 4", q_count, f_pc); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failed++; $display("[TB] FAIL refill: got %0h@%h expected 1@10", imem_req, imem_addr); end
  endtask

  task automatic test_push_pop();
    bit seen = 1'b0;
    do_reset(1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      #3;
      if (q_count == 3'd2) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin failed++; $display("[TB] FAIL pp_timeout: got no count of 2 expected within 20 cycles"); end
    tick();
    f_ready = 1'b1;
    #3;
    tests++; if (imem_ack !== 1'b1 || q_count !== 3'd2) begin failed++; $display("[TB] FAIL pp_setup: got ack %0h count %0d expected 1 2", imem_ack, q_count); end
    tick();
    f_ready = 1'b0;
    #3;
    tests++; if (q_count !== 3'd2 || f_pc !== 32'h4) begin failed++; $display("[TB] FAIL pp_count: got count %0d pc %h expected 2 4", q_count, f_pc); end
    tick();
    f_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    f_ready = 1'b0; redirect = 1'b0;
    #3;
    tests++; if (q_count !== 3'd0 || f_valid !== 1'b0) begin failed++; $display("[TB] FAIL pop_redirect: got count %0d valid %0h expected 0 0", q_count, f_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failed++; $display("[TB] FAIL pop_redirect_req: got %0h@%h expected 1@40", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drain();
    bit seen = 1'b0;
    do_reset(3, 1'b1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL rd_gate: got %0h expected 0", imem_req); end
    tick();
    redirect = 1'b0;
    #3;
    tests++; if (imem_req !== 1'b0 || q_count !== 3'd0) begin failed++; $display("[TB] FAIL rd_drain: got req %0h count %0d expected 0 0", imem_req, q_count); end
    tick();
    #3;
    tests++; if (imem_ack !== 1'b1 || imem_req !== 1'b0) begin failed++; $display("[TB] FAIL rd_stale: got ack %0h req %0h expected 1 0", imem_ack, imem_req); end
    tick();
    #3;
    tests++; if (q_count !== 3'd0 || f_valid !== 1'b0) begin failed++; $display("[TB] FAIL rd_dropped: got count %0d valid %0h expected 0 0", q_count, f_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failed++; $display("[TB] FAIL rd_next: got %0h@%h expected 1@100", imem_req, imem_addr); end
    for (int i = 0; i < 12; i++) begin
      tick();
      #3;
      if (f_valid) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin
      failed++; $display("[TB] FAIL rd_timeout: got no valid expected within 12 cycles");
    end else if (f_pc !== 32'h100 || f_pc_plus4 !== 32'h104 || f_instruction !== mem_word(32'h100)) begin
      failed++; $display("[TB] FAIL rd_head: got %h/%h/%h expected 100/104/%h", f_pc, f_pc_plus4, f_instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    do_reset(3, 1'b1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL b2b_gate: got %0h expected 0", imem_req); end
    tick();
    redirect = 1'b0;
    #3;
    tests++; if (imem_ack !== 1'b1 || imem_req !== 1'b0) begin failed++; $display("[TB] FAIL b2b_drain: got ack %0h req %0h expected 1 0", imem_ack, imem_req); end
    tick();
    #3;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failed++; $display("[TB] FAIL b2b_last: got %0h@%h expected 1@200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL wrap_gate: got %0h expected 0", imem_req); end
    tick();
    redirect = 1'b0;
    #3;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("[TB] FAIL wrap_issue: got %0h@%h expected 1@fffffffc", imem_req, imem_addr); end
    tick();
    tick();
    #3;
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'hFFFF_FFFC || f_pc_plus4 !== 32'h0) begin failed++; $display("[TB] FAIL wrap_head: got %0h %h/%h expected 1 fffffffc/0", f_valid, f_pc, f_pc_plus4); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("[TB] FAIL wrap_next: got %0h@%h expected 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_abort();
    do_reset(3, 1'b1);
    tick();
    #3;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("[TB] FAIL abort_wait: got %0h expected 0", imem_req); end
    reset = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0 || q_count !== 3'd0) begin failed++; $display("[TB] FAIL abort_async: got req %0h count %0d expected 0 0", imem_req, q_count); end
    tick();
    tick();
    reset = 1'b1;
    #3;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("[TB] FAIL abort_restart: got %0h@%h expected 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_perf();
    bit seen = 1'b0;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef FETCH_PERF_EN
    exp_stall = 32'd5; exp_flush = 32'd2;
`else
    exp_stall = 32'd0; exp_flush = 32'd0;
`endif
    do_reset(1, 1'b0);
    #3;
    tests++; if ({perf_stall, perf_flush} !== 64'h0) begin failed++; $display("[TB] FAIL perf_init: got %0d/%0d expected 0/0", perf_stall, perf_flush); end
    for (int i = 0; i < 10; i++) begin
      tick();
      #3;
      if (f_valid) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin failed++; $display("[TB] FAIL perf_timeout: got no valid expected within 10 cycles"); end
    repeat (4) tick();
    tick();
    f_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h90;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    #3;
    tests++; if (perf_stall !== exp_stall) begin failed++; $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall, exp_stall); end
    tests++; if (perf_flush !== exp_flush) begin failed++; $display("[TB] FAIL perf_flush: got %0d expected %0d", perf_flush, exp_flush); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_push_pop();
    test_redirect_drain();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
